// File: rtl/bcd_mmss_counter.sv
// BCD minutes:seconds counter (00:00 .. MIN_MAX:59) for the StopWatch datapath.
// Tick-enabled up/down counting, with saturate-or-wrap at the terminal and per-field adjust.
module bcd_mmss_counter #(
  parameter int MIN_MAX = 59,
  parameter bit WRAP    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause,
  input  logic       down,
  input  logic       adj,
  input  logic       sel,
  input  logic       adj_tick,
  output logic [3:0] led_0,
  output logic [3:0] led_1,
  output logic [3:0] led_2,
  output logic [3:0] led_3,
  output logic       at_limit,
  output logic       rollover
);

  localparam logic [3:0] MAX_H = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_L = 4'(MIN_MAX % 10);

  logic [3:0] sec_l, sec_h, min_l, min_h;
  logic       sec_is_max, min_is_max, sec_is_zero, min_is_zero;
  logic       at_up, at_dn;

  assign sec_is_max  = (sec_h == 4'd5) && (sec_l == 4'd9);
  assign min_is_max  = (min_h == MAX_H) && (min_l == MAX_L);
  assign sec_is_zero = (sec_h == 4'd0) && (sec_l == 4'd0);
  assign min_is_zero = (min_h == 4'd0) && (min_l == 4'd0);
  assign at_up       = min_is_max && sec_is_max;
  assign at_dn       = min_is_zero && sec_is_zero;

  assign at_limit = down ? at_dn : at_up;
  assign led_0    = sec_l;
  assign led_1    = sec_h;
  assign led_2    = min_l;
  assign led_3    = min_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_l    <= 4'd0;
      sec_h    <= 4'd0;
      min_l    <= 4'd0;
      min_h    <= 4'd0;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;
      if (!pause) begin
        if (adj) begin
          // Adjust steps one field only; it never carries across fields or pulses rollover.
          if (adj_tick && !sel) begin
            if (sec_is_max) begin
              sec_l <= 4'd0;
              sec_h <= 4'd0;
            end else if (sec_l != 4'd9) begin
              sec_l <= sec_l + 4'd1;
            end else begin
              sec_l <= 4'd0;
              sec_h <= sec_h + 4'd1;
            end
          end else if (adj_tick && sel) begin
            if (min_is_max) begin
              min_l <= 4'd0;
              min_h <= 4'd0;
            end else if (min_l != 4'd9) begin
              min_l <= min_l + 4'd1;
            end else begin
              min_l <= 4'd0;
              min_h <= min_h + 4'd1;
            end
          end
        end else if (tick && !down) begin
          if (at_up) begin
            if (WRAP) begin
              sec_l    <= 4'd0;
              sec_h    <= 4'd0;
              min_l    <= 4'd0;
              min_h    <= 4'd0;
              rollover <= 1'b1;
            end
          end else if (sec_l != 4'd9) begin
            sec_l <= sec_l + 4'd1;
          end else begin
            sec_l <= 4'd0;
            if (sec_h != 4'd5) begin
              sec_h <= sec_h + 4'd1;
            end else begin
              sec_h <= 4'd0;
              if (min_l != 4'd9) begin
                min_l <= min_l + 4'd1;
              end else begin
                min_l <= 4'd0;
                min_h <= min_h + 4'd1;
              end
            end
          end
        end else if (tick && down) begin
          if (at_dn) begin
            if (WRAP) begin
              sec_l    <= 4'd9;
              sec_h    <= 4'd5;
              min_l    <= MAX_L;
              min_h    <= MAX_H;
              rollover <= 1'b1;
            end
          end else if (sec_l != 4'd0) begin
            sec_l <= sec_l - 4'd1;
          end else begin
            sec_l <= 4'd9;
            if (sec_h != 4'd0) begin
              sec_h <= sec_h - 4'd1;
            end else begin
              sec_h <= 4'd5;
              if (min_l != 4'd0) begin
                min_l <= min_l - 4'd1;
              end else begin
                min_l <= 4'd9;
                min_h <= min_h - 4'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_mmss_counter.sv
// Bench for bcd_mmss_counter: three instances (59/saturate, 59/wrap, 9/wrap) share stimulus;
// a total-seconds reference model feeds an expected queue checked after every edge.
module tb_bcd_mmss_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, tick = 1'b0, pause = 1'b0, down = 1'b0;
  logic adj = 1'b0, sel = 1'b0, adj_tick = 1'b0;

  logic [3:0] led_0 [3];
  logic [3:0] led_1 [3];
  logic [3:0] led_2 [3];
  logic [3:0] led_3 [3];
  logic       at_limit [3];
  logic       rollover [3];

  bcd_mmss_counter #(.MIN_MAX(59), .WRAP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .down(down), .adj(adj), .sel(sel),
    .adj_tick(adj_tick), .led_0(led_0[0]), .led_1(led_1[0]), .led_2(led_2[0]), .led_3(led_3[0]),
    .at_limit(at_limit[0]), .rollover(rollover[0]));

  bcd_mmss_counter #(.MIN_MAX(59), .WRAP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .down(down), .adj(adj), .sel(sel),
    .adj_tick(adj_tick), .led_0(led_0[1]), .led_1(led_1[1]), .led_2(led_2[1]), .led_3(led_3[1]),
    .at_limit(at_limit[1]), .rollover(rollover[1]));

  bcd_mmss_counter #(.MIN_MAX(9), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .tick(tick), .pause(pause), .down(down), .adj(adj), .sel(sel),
    .adj_tick(adj_tick), .led_0(led_0[2]), .led_1(led_1[2]), .led_2(led_2[2]), .led_3(led_3[2]),
    .at_limit(at_limit[2]), .rollover(rollover[2]));

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  int tot [3];
  bit roll [3];

  function automatic int mm_of(int i);
    return (i == 2) ? 9 : 59;
  endfunction

  function automatic bit wr_of(int i);
    return (i != 0);
  endfunction

  // Reference model works on total seconds, then splits into BCD digits for comparison.
  task automatic model_step(input int i);
    int top, s, m;
    top = mm_of(i) * 60 + 59;
    s = tot[i] % 60;
    m = tot[i] / 60;
    roll[i] = 1'b0;
    if (rst) begin
      tot[i] = 0;
    end else if (pause) begin
    end else if (adj) begin
      if (adj_tick && !sel) tot[i] = m * 60 + ((s == 59) ? 0 : s + 1);
      else if (adj_tick && sel) tot[i] = ((m == mm_of(i)) ? 0 : m + 1) * 60 + s;
    end else if (tick && !down) begin
      if (tot[i] == top) begin
        if (wr_of(i)) begin tot[i] = 0; roll[i] = 1'b1; end
      end else tot[i] = tot[i] + 1;
    end else if (tick && down) begin
      if (tot[i] == 0) begin
        if (wr_of(i)) begin tot[i] = top; roll[i] = 1'b1; end
      end else tot[i] = tot[i] - 1;
    end
  endtask

  function automatic logic [17:0] exp_vec(input int i);
    int s, m, top;
    logic lim;
    top = mm_of(i) * 60 + 59;
    s = tot[i] % 60;
    m = tot[i] / 60;
    lim = down ? (tot[i] == 0) : (tot[i] == top);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), lim, roll[i]};
  endfunction

  task automatic step(input bit r, input bit p, input bit t, input bit d, input bit a,
                      input bit s, input bit at, input string tag);
    logic [17:0] exp, obs;
    @(negedge clk);
    rst = r; pause = p; tick = t; down = d; adj = a; sel = s; adj_tick = at;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      exp_q.push_back(exp_vec(i));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp = exp_q.pop_front();
      obs = {led_3[i], led_2[i], led_1[i], led_0[i], at_limit[i], rollover[i]};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s dut%0d: got %h:%h%h:%h lim=%b roll=%b, expected %h:%h%h:%h lim=%b roll=%b",
               tag, i, obs[17:14], obs[13:10], obs[9:6], obs[5:2], obs[1], obs[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end
    end
  endtask

  // Adjust n times on one field, with an ignored tick interleaved on odd steps.
  task automatic adjust_n(input int n, input bit s, input bit d, input string tag);
    for (int k = 0; k < n; k++) step(0, 0, k[0], d, 1, s, 1, tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin tot[i] = 0; roll[i] = 1'b0; end

    step(1, 0, 1, 0, 0, 0, 1, "reset");
    for (int k = 0; k < 65; k++) step(0, 0, 1, 0, 0, 0, 0, "up65");
    step(0, 0, 0, 0, 0, 0, 0, "idle_hold");

    // Up terminal: 59:58 then three ticks.
    step(1, 0, 0, 0, 0, 0, 0, "reset2");
    adjust_n(59, 1, 0, "adj_min59");
    adjust_n(58, 0, 0, "adj_sec58");
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0, 0, "terminal_up");

    // Down: borrow, run to zero, then terminal.
    step(1, 0, 0, 1, 0, 0, 0, "reset_down");
    adjust_n(1, 1, 1, "adj_min1");
    step(0, 0, 1, 1, 0, 0, 0, "down_borrow");
    for (int k = 0; k < 59; k++) step(0, 0, 1, 1, 0, 0, 0, "down_run");
    step(0, 0, 1, 1, 0, 0, 0, "down_wrap");
    step(0, 0, 1, 1, 0, 0, 0, "down_after_wrap");
    step(0, 0, 1, 0, 0, 0, 0, "dir_change");

    // Field adjust wrap points.
    step(1, 0, 0, 0, 0, 0, 0, "reset3");
    adjust_n(12, 1, 0, "adj_min12");
    adjust_n(59, 0, 0, "adj_sec59");
    adjust_n(1, 0, 0, "adj_sec_wrap");
    adjust_n(60, 1, 0, "adj_min_wrap");

    // Pause freezes everything, including adjust.
    for (int k = 0; k < 10; k++)
      step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "pause");
    step(0, 0, 1, 0, 0, 0, 0, "pause_release");

    // Reset wins over a wrapping tick at 59:59.
    step(1, 0, 0, 0, 0, 0, 0, "reset4");
    adjust_n(59, 1, 0, "adj_min59b");
    adjust_n(59, 0, 0, "adj_sec59b");
    step(1, 1, 1, 0, 0, 0, 1, "rst_on_wrap");
    step(0, 0, 1, 0, 0, 0, 0, "after_rst");

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
